// File: rtl/fwl_pkg.sv
// fwl_pkg: shared types and constants for the flowing-water-light design
package fwl_pkg;
    localparam int CLK_HZ = 100_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_PRESS_CYCLES_DEF = 100_000_000;
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} btn_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with a configurable reset value
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    // two-stage capture of an asynchronous input into clk
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise, debounce and pulse-encode a push-button
module button_debouncer
    import fwl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX = HW'(LONG_PRESS_CYCLES);

    logic btn_in;
    logic btn_sync;
    btn_state_t state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic long_done_q, long_done_d;
    logic held;
    logic ev_press_q, ev_press_d;
    logic ev_release_q, ev_release_d;
    logic ev_long_q, ev_long_d;
    logic ev_level_q, ev_level_d;
    logic level_q, press_q, release_q, long_q;

    assign btn_in = btn_raw ^ ACTIVE_LOW;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (btn_sync)
    );

    // state, counters and the event stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            long_done_q  <= 1'b0;
            ev_press_q   <= 1'b0;
            ev_release_q <= 1'b0;
            ev_long_q    <= 1'b0;
            ev_level_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            hcnt_q       <= hcnt_d;
            long_done_q  <= long_done_d;
            ev_press_q   <= ev_press_d;
            ev_release_q <= ev_release_d;
            ev_long_q    <= ev_long_d;
            ev_level_q   <= ev_level_d;
        end
    end

    // output flops: one stage after the events, so press/release land
    // DEBOUNCE_CYCLES+2 edges after the first pin sample
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            level_q   <= ev_level_q;
            press_q   <= ev_press_q;
            release_q <= ev_release_q;
            long_q    <= ev_long_q;
        end
    end

    // next state: count consecutive identical samples before accepting a change
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: if (btn_sync) begin
                state_d = WAIT_PRESS;
                dcnt_d  = DW'(1);
            end
            WAIT_PRESS: if (!btn_sync) state_d = IDLE;
                else if (dcnt_q == D_LAST) state_d = PRESSED;
                else dcnt_d = dcnt_q + 1'b1;
            PRESSED: if (!btn_sync) begin
                state_d = WAIT_RELEASE;
                dcnt_d  = DW'(1);
            end
            WAIT_RELEASE: if (btn_sync) state_d = PRESSED;
                else if (dcnt_q == D_LAST) state_d = IDLE;
                else dcnt_d = dcnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // events and hold timing; hcnt survives a release bounce, long fires once per press
    always_comb begin
        held         = state_q == PRESSED || state_q == WAIT_RELEASE;
        ev_press_d   = state_q == WAIT_PRESS && state_d == PRESSED;
        ev_release_d = state_q == WAIT_RELEASE && state_d == IDLE;
        ev_long_d    = held && hcnt_q == H_LAST && !long_done_q;
        ev_level_d   = state_d == PRESSED || state_d == WAIT_RELEASE;
        hcnt_d       = ev_press_d ? '0 : (held && hcnt_q != H_MAX) ? hcnt_q + 1'b1 : hcnt_q;
        long_done_d  = ev_press_d ? 1'b0 : long_done_q | ev_long_d;
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of debounce timing, pulses and polarity
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw0 = 1'b0;
    logic raw1 = 1'b1;
    logic lvl0, prs0, rel0, lng0, lvl1, prs1, rel1, lng1;
    logic [3:0] out0, out1;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       raw;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[24];

    always #5 clk = ~clk;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .btn_raw(raw0),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_long(lng0)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .btn_raw(raw1),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_long(lng1)
    );

    // {level, press, release, long}
    assign out0 = {lvl0, prs0, rel0, lng0};
    assign out1 = {lvl1, prs1, rel1, lng1};

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got {lvl,prs,rel,lng}=%b want=%b", name, idx, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic b0, input logic b1);
        rst  = r;
        raw0 = b0;
        raw1 = b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] pat;
        logic b;
        logic [3:0] e;
        pat = 5'b01101;
        vecs = '{
            '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000}, '{1'b1, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000},
            '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b0000},
            '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 4'b1100}, '{1'b0, 1'b1, 4'b1000},
            '{1'b0, 1'b1, 4'b1000}, '{1'b0, 1'b1, 4'b1000}, '{1'b0, 1'b0, 4'b1000}, '{1'b0, 1'b0, 4'b1000},
            '{1'b0, 1'b0, 4'b1000}, '{1'b0, 1'b0, 4'b1000}, '{1'b0, 1'b0, 4'b1000}, '{1'b0, 1'b0, 4'b1000},
            '{1'b0, 1'b0, 4'b0010}, '{1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b0, 4'b0000}
        };
        // reset, clean press at row 4, release at row 14
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].rst, vecs[i].raw, 1'b1);
            chk("table", i, out0, vecs[i].exp);
        end
        // idle after reset: nothing moves on either polarity
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("idle0", i, out0, 4'b0000);
            chk("idle1", i, out1, 4'b0000);
        end
        // bounce, long hold, 2-cycle release glitch, then real release
        for (int k = 0; k <= 70; k++) begin
            b = (k < 5) ? pat[k] : (k == 52 || k == 53 || k >= 61) ? 1'b0 : 1'b1;
            e = {k >= 11 && k < 67, k == 11, k == 67, k == 27};
            step(1'b0, b, 1'b1);
            chk("seq", k, out0, e);
        end
        // inverted pin: press, reset while PRESSED, button held through reset release
        for (int k = 0; k <= 22; k++) begin
            e = (k <= 10) ? {k >= 6, k == 6, 2'b00} : (k <= 12) ? 4'b0000 : {k >= 19, k == 19, 2'b00};
            step(k == 11 || k == 12, 1'b0, 1'b0);
            chk("alow", k, out1, e);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
